// File: rtl/rx_buffered_pkg.sv
// Shared definitions for the buffered NoC input-port receiver:
// output-FSM state encoding and flit-counter sizing.
package rx_buffered_pkg;

   // Output-side FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUTE = 2'd1,
      ST_REQ   = 2'd2,
      ST_SEND  = 2'd3
   } rx_state_t;

   // Flit counter is wide enough for packets of up to 255 flits
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_ZERO = 8'd0;
   localparam logic [CNT_W-1:0] CNT_ONE  = 8'd1;

endpackage

// File: rtl/flit_fifo.sv
// First-word-fall-through flit FIFO with occupancy count.
// Pointers wrap modulo DEPTH; a push when full or a pop when empty is ignored.
module flit_fifo #(
   parameter int SIZE      = 8,
   parameter int BUFF_BITS = 3
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic                 pop,
   input  logic [SIZE-1:0]      din,
   output logic [SIZE-1:0]      dout,
   output logic [BUFF_BITS:0]   count,
   output logic                 full,
   output logic                 empty
);
   localparam int DEPTH = 2 ** BUFF_BITS;
   localparam logic [BUFF_BITS:0]   CNT_FULL = {1'b1, {BUFF_BITS{1'b0}}};
   localparam logic [BUFF_BITS:0]   CNT_ONE  = {{BUFF_BITS{1'b0}}, 1'b1};
   localparam logic [BUFF_BITS-1:0] PTR_ONE  = {{(BUFF_BITS-1){1'b0}}, 1'b1};

   logic [SIZE-1:0]      mem [DEPTH];
   logic [BUFF_BITS-1:0] wr_ptr;
   logic [BUFF_BITS-1:0] rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   // Status flags, guarded push/pop and fall-through read data
   always_comb begin
      full    = (count == CNT_FULL);
      empty   = (count == {(BUFF_BITS+1){1'b0}});
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      dout    = mem[rd_ptr];
   end

   // Storage array write; contents need no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy tracking; simultaneous push/pop keeps count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= {BUFF_BITS{1'b0}};
         rd_ptr <= {BUFF_BITS{1'b0}};
         count  <= {(BUFF_BITS+1){1'b0}};
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rx_buffered.sv
// Buffered NoC input-port receiver: two-phase channel input into a FIFO,
// head-flit route decode, switch req/gnt arbitration and packet streaming.
module rx_buffered
   import rx_buffered_pkg::*;
#(
   parameter int SIZE         = 8,
   parameter int CHANNEL_BITS = 3,
   parameter int BUFF_BITS    = 3,
   parameter int PKT_LEN      = 8
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ch_req,
   input  logic [SIZE-1:0]         ch_flit,
   output logic                    ch_ack,
   output logic                    sw_req,
   output logic [CHANNEL_BITS-1:0] sw_chnl,
   input  logic                    sw_gnt,
   output logic                    sw_valid,
   output logic [SIZE-1:0]         sw_flit,
   output logic                    sw_tail,
   output logic                    err_drop,
   output logic [BUFF_BITS:0]      fifo_count
);
   localparam int HEAD_BIT = SIZE - 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

   rx_state_t        state;
   logic [CNT_W-1:0] flit_cnt;
   logic [SIZE-1:0]  head_flit;
   logic             full;
   logic             empty;
   logic             pending;
   logic             push;
   logic             pop;
   logic             drop;
   logic             transfer;

   flit_fifo #(
      .SIZE      (SIZE),
      .BUFF_BITS (BUFF_BITS)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (ch_flit),
      .dout  (head_flit),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   assign sw_flit = head_flit;

   // Handshake decode, switch-side valid/tail and FIFO pop sources
   always_comb begin
      pending  = (ch_req != ch_ack);
      push     = pending & ~full;
      sw_valid = (state == ST_SEND) & ~empty;
      sw_tail  = sw_valid & (flit_cnt == LAST_IDX);
      transfer = sw_valid & sw_gnt;
      drop     = (state == ST_IDLE) & ~empty & ~head_flit[HEAD_BIT];
      pop      = transfer | drop;
   end

   // Two-phase acknowledge: toggle once for each flit written into the FIFO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ch_ack <= 1'b0;
      end else if (push) begin
         ch_ack <= ~ch_ack;
      end else begin
         ch_ack <= ch_ack;
      end
   end

   // Output FSM: route head flit, request switch, stream PKT_LEN flits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         sw_req   <= 1'b0;
         sw_chnl  <= {CHANNEL_BITS{1'b0}};
         flit_cnt <= CNT_ZERO;
         err_drop <= 1'b0;
      end else begin
         err_drop <= drop;
         case (state)
            ST_IDLE: begin
               if (!empty && head_flit[HEAD_BIT]) begin
                  state <= ST_ROUTE;
               end
            end
            ST_ROUTE: begin
               sw_chnl <= head_flit[SIZE-2 -: CHANNEL_BITS];
               sw_req  <= 1'b1;
               state   <= ST_REQ;
            end
            ST_REQ: begin
               if (sw_gnt) begin
                  state <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (transfer) begin
                  if (flit_cnt == LAST_IDX) begin
                     sw_req   <= 1'b0;
                     flit_cnt <= CNT_ZERO;
                     state    <= ST_IDLE;
                  end else begin
                     flit_cnt <= flit_cnt + CNT_ONE;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               sw_req   <= 1'b0;
               flit_cnt <= CNT_ZERO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_buffered.sv
// Self-checking bench for rx_buffered: directed scenarios plus randomized
// packet/orphan streams checked against a packet-parsing reference model.
module tb_rx_buffered;
   localparam int PKT = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   logic       ch_req = 1'b0;
   logic [7:0] ch_flit = 8'h00;
   logic       ch_ack;
   logic       sw_req;
   logic [2:0] sw_chnl;
   logic       sw_gnt = 1'b0;
   logic       sw_valid;
   logic [7:0] sw_flit;
   logic       sw_tail;
   logic       err_drop;
   logic [3:0] fifo_count;

   logic       p1_req = 1'b0;
   logic [7:0] p1_flit = 8'h00;
   logic       p1_ack;
   logic       p1_sw_req;
   logic [2:0] p1_sw_chnl;
   logic       p1_sw_gnt = 1'b0;
   logic       p1_sw_valid;
   logic [7:0] p1_sw_flit;
   logic       p1_sw_tail;
   logic       p1_err_drop;
   logic [3:0] p1_fifo_count;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] got_flit[$];
   bit         got_tail[$];
   logic [2:0] got_chnl[$];
   bit         got_req[$];
   int         drops = 0;
   int         ack_toggles = 0;
   logic       prev_ack = 1'b0;

   logic [7:0] p1_got_flit[$];
   bit         p1_got_tail[$];
   logic [2:0] p1_got_chnl[$];

   always #5 clk = ~clk;

   rx_buffered #(.SIZE(8), .CHANNEL_BITS(3), .BUFF_BITS(3), .PKT_LEN(PKT)) dut (
      .clk(clk), .reset(reset), .ch_req(ch_req), .ch_flit(ch_flit), .ch_ack(ch_ack),
      .sw_req(sw_req), .sw_chnl(sw_chnl), .sw_gnt(sw_gnt), .sw_valid(sw_valid),
      .sw_flit(sw_flit), .sw_tail(sw_tail), .err_drop(err_drop), .fifo_count(fifo_count)
   );

   rx_buffered #(.SIZE(8), .CHANNEL_BITS(3), .BUFF_BITS(3), .PKT_LEN(1)) dut1 (
      .clk(clk), .reset(reset), .ch_req(p1_req), .ch_flit(p1_flit), .ch_ack(p1_ack),
      .sw_req(p1_sw_req), .sw_chnl(p1_sw_chnl), .sw_gnt(p1_sw_gnt), .sw_valid(p1_sw_valid),
      .sw_flit(p1_sw_flit), .sw_tail(p1_sw_tail), .err_drop(p1_err_drop), .fifo_count(p1_fifo_count)
   );

   // Record every switch transfer, drop pulse and ack toggle of the main DUT
   always @(negedge clk) begin
      if (!reset) begin
         if (sw_valid && sw_gnt) begin
            got_flit.push_back(sw_flit);
            got_tail.push_back(sw_tail);
            got_chnl.push_back(sw_chnl);
            got_req.push_back(sw_req);
         end
         if (err_drop) drops <= drops + 1;
         if (ch_ack != prev_ack) ack_toggles <= ack_toggles + 1;
      end
      prev_ack <= ch_ack;
   end

   // Record switch transfers of the single-flit-packet DUT
   always @(negedge clk) begin
      if (!reset && p1_sw_valid && p1_sw_gnt) begin
         p1_got_flit.push_back(p1_sw_flit);
         p1_got_tail.push_back(p1_sw_tail);
         p1_got_chnl.push_back(p1_sw_chnl);
      end
   end

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, %0d vectors applied", vectors);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send_flit(input logic [7:0] f);
      int n = 0;
      while (ch_req != ch_ack && n < 300) begin
         @(posedge clk); #1; n++;
      end
      if (ch_req != ch_ack) begin
         vectors++; miscompares++;
         $display("FAIL send_timeout: flit %h still blocked, ack %b req %b", f, ch_ack, ch_req);
      end else begin
         ch_flit = f;
         ch_req  = ~ch_req;
      end
      @(posedge clk); #1;
   endtask

   task automatic send_flit1(input logic [7:0] f);
      int n = 0;
      while (p1_req != p1_ack && n < 300) begin
         @(posedge clk); #1; n++;
      end
      if (p1_req != p1_ack) begin
         vectors++; miscompares++;
         $display("FAIL send1_timeout: flit %h still blocked", f);
      end else begin
         p1_flit = f;
         p1_req  = ~p1_req;
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_got(input int target);
      int n = 0;
      while (got_flit.size() < target && n < 1000) begin
         tick(); n++;
      end
      if (got_flit.size() < target) begin
         vectors++; miscompares++;
         $display("FAIL wait_transfers: got %0d transfers, required %0d", got_flit.size(), target);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; ch_req = 1'b0; sw_gnt = 1'b0; p1_req = 1'b0; p1_sw_gnt = 1'b0;
      repeat (2) tick();
      vectors++;
      if ({ch_ack, sw_req, sw_chnl, sw_valid, sw_tail, err_drop} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_outputs: got ack/req/chnl/valid/tail/err %b, required 00000000",
                  {ch_ack, sw_req, sw_chnl, sw_valid, sw_tail, err_drop});
      end
      vectors++;
      if (fifo_count !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_count: got %0d, required 0", fifo_count);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      tick();
   endtask

   task automatic check_packet(input string name, input int base, input logic [7:0] exp_f[$],
                               input logic [2:0] exp_c);
      for (int i = 0; i < exp_f.size(); i++) begin
         if (base + i < got_flit.size()) begin
            vectors++;
            if (got_flit[base+i] !== exp_f[i] || got_tail[base+i] !== (i == exp_f.size() - 1) ||
                got_chnl[base+i] !== exp_c || got_req[base+i] !== 1'b1) begin
               miscompares++;
               $display("FAIL %s[%0d]: got flit %h tail %b chnl %0d req %b, required flit %h tail %b chnl %0d req 1",
                        name, i, got_flit[base+i], got_tail[base+i], got_chnl[base+i], got_req[base+i],
                        exp_f[i], (i == exp_f.size() - 1), exp_c);
            end
         end
      end
   endtask

   task automatic test_basic();
      int base = got_flit.size();
      logic [7:0] exp_f[$];
      sw_gnt = 1'b1;
      exp_f.push_back(8'hD0);
      for (int i = 1; i < PKT; i++) exp_f.push_back(8'(i));
      foreach (exp_f[i]) send_flit(exp_f[i]);
      wait_got(base + PKT);
      check_packet("basic", base, exp_f, 3'd5);
      repeat (3) tick();
      vectors++;
      if (sw_req !== 1'b0 || got_flit.size() !== base + PKT) begin
         miscompares++;
         $display("FAIL basic_end: got sw_req %b transfers %0d, required 0 and %0d",
                  sw_req, got_flit.size() - base, PKT);
      end
   endtask

   task automatic test_full();
      int base = got_flit.size();
      int a0 = ack_toggles;
      int d0 = drops;
      int n = 0;
      logic [7:0] exp_f[$];
      sw_gnt = 1'b0;
      exp_f.push_back(8'h90);
      for (int i = 1; i < PKT; i++) exp_f.push_back(8'h50 + 8'(i));
      foreach (exp_f[i]) send_flit(exp_f[i]);
      send_flit(8'h44);
      repeat (4) tick();
      vectors++;
      if (ack_toggles - a0 !== 8 || fifo_count !== 4'd8 || (ch_req == ch_ack)) begin
         miscompares++;
         $display("FAIL full_hold: got toggles %0d count %0d pending %b, required 8, 8, 1",
                  ack_toggles - a0, fifo_count, ch_req != ch_ack);
      end
      @(posedge clk); #1;
      sw_gnt = 1'b1;
      while (got_flit.size() == base && n < 50) begin tick(); n++; end
      tick();
      vectors++;
      if ((ch_req == ch_ack) || fifo_count !== 4'd7) begin
         miscompares++;
         $display("FAIL full_first_pop: got pending %b count %0d, required 1 and 7",
                  ch_req != ch_ack, fifo_count);
      end
      tick();
      vectors++;
      if ((ch_req != ch_ack) || ack_toggles - a0 !== 9) begin
         miscompares++;
         $display("FAIL full_accept9: got pending %b toggles %0d, required 0 and 9",
                  ch_req != ch_ack, ack_toggles - a0);
      end
      wait_got(base + PKT);
      check_packet("full", base, exp_f, 3'd1);
      repeat (4) tick();
      vectors++;
      if (drops - d0 !== 1 || fifo_count !== 4'd0 || sw_req !== 1'b0) begin
         miscompares++;
         $display("FAIL full_drop9: got drops %0d count %0d req %b, required 1, 0, 0",
                  drops - d0, fifo_count, sw_req);
      end
   endtask

   task automatic test_orphan();
      int d0 = drops;
      int base = got_flit.size();
      bit req_seen = 1'b0;
      sw_gnt = 1'b1;
      send_flit(8'h33);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (sw_req) req_seen = 1'b1;
      end
      vectors++;
      if (drops - d0 !== 1 || fifo_count !== 4'd0 || req_seen || got_flit.size() !== base) begin
         miscompares++;
         $display("FAIL orphan: got drops %0d count %0d req_seen %b transfers %0d, required 1, 0, 0, 0",
                  drops - d0, fifo_count, req_seen, got_flit.size() - base);
      end
   endtask

   task automatic test_pause();
      int base = got_flit.size();
      int n = 0;
      logic [7:0] exp_f[$];
      sw_gnt = 1'b0;
      exp_f.push_back(8'hE0);
      for (int i = 1; i < PKT; i++) exp_f.push_back(8'h10 + 8'(i));
      foreach (exp_f[i]) send_flit(exp_f[i]);
      sw_gnt = 1'b1;
      while (got_flit.size() < base + 4 && n < 100) begin tick(); n++; end
      @(posedge clk); #1;
      sw_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (got_flit.size() !== base + 4 || sw_req !== 1'b1) begin
            miscompares++;
            $display("FAIL pause_gap%0d: got transfers %0d sw_req %b, required 4 and 1",
                     i, got_flit.size() - base, sw_req);
         end
      end
      @(posedge clk); #1;
      sw_gnt = 1'b1;
      wait_got(base + PKT);
      check_packet("pause", base, exp_f, 3'd6);
      repeat (3) tick();
   endtask

   task automatic test_reset_mid();
      int base;
      logic [7:0] exp_f[$];
      sw_gnt = 1'b0;
      send_flit(8'hC0);
      for (int i = 1; i < 5; i++) send_flit(8'h20 + 8'(i));
      repeat (3) tick();
      @(posedge clk); #1; sw_gnt = 1'b1;
      @(posedge clk); #1; sw_gnt = 1'b0;
      tick();
      vectors++;
      if (sw_valid !== 1'b1 || fifo_count !== 4'd5) begin
         miscompares++;
         $display("FAIL midrst_pre: got valid %b count %0d, required 1 and 5", sw_valid, fifo_count);
      end
      reset = 1'b1;
      ch_req = 1'b0;
      tick();
      vectors++;
      if ({ch_ack, sw_req, sw_chnl, sw_valid, sw_tail, err_drop} !== 8'h00 || fifo_count !== 4'd0) begin
         miscompares++;
         $display("FAIL midrst_outputs: got ack/req/chnl/valid/tail/err %b count %0d, required 0 and 0",
                  {ch_ack, sw_req, sw_chnl, sw_valid, sw_tail, err_drop}, fifo_count);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      base = got_flit.size();
      sw_gnt = 1'b1;
      exp_f.push_back(8'hA0);
      for (int i = 1; i < PKT; i++) exp_f.push_back(8'h30 + 8'(i));
      foreach (exp_f[i]) send_flit(exp_f[i]);
      wait_got(base + PKT);
      check_packet("midrst_fresh", base, exp_f, 3'd2);
      repeat (3) tick();
   endtask

   task automatic test_random(input int rounds);
      for (int r = 0; r < rounds; r++) begin
         logic [7:0] sent[$];
         logic [7:0] ef[$];
         bit         et[$];
         logic [2:0] ec[$];
         logic [2:0] cur;
         int edrops, base, dbase, pos, items;
         bit in_pkt, done;
         cur = 3'd0; edrops = 0; pos = 0; in_pkt = 1'b0; done = 1'b0;
         items = $urandom_range(2, 5);
         for (int i = 0; i < items; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               sent.push_back(8'($urandom_range(0, 127)));
            end else begin
               sent.push_back({1'b1, 7'($urandom)});
               for (int k = 1; k < PKT; k++) sent.push_back(8'($urandom));
            end
         end
         // Reference: split the flit stream into packets and orphans
         foreach (sent[i]) begin
            if (!in_pkt) begin
               if (sent[i][7]) begin
                  cur = sent[i][6:4];
                  ef.push_back(sent[i]); ec.push_back(cur); et.push_back(PKT == 1);
                  pos = 1; in_pkt = (PKT > 1);
               end else begin
                  edrops++;
               end
            end else begin
               ef.push_back(sent[i]); ec.push_back(cur); et.push_back(pos == PKT - 1);
               pos++;
               if (pos == PKT) in_pkt = 1'b0;
            end
         end
         base = got_flit.size();
         dbase = drops;
         fork
            begin
               foreach (sent[i]) begin
                  repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                  send_flit(sent[i]);
               end
               done = 1'b1;
            end
            begin
               while (!done) begin
                  @(posedge clk); #1;
                  sw_gnt = ($urandom_range(0, 3) != 0);
               end
            end
         join
         sw_gnt = 1'b1;
         wait_got(base + ef.size());
         repeat (4) tick();
         for (int i = 0; i < ef.size(); i++) begin
            if (base + i < got_flit.size()) begin
               vectors++;
               if (got_flit[base+i] !== ef[i] || got_tail[base+i] !== et[i] || got_chnl[base+i] !== ec[i]) begin
                  miscompares++;
                  $display("FAIL rand%0d[%0d]: got flit %h tail %b chnl %0d, required flit %h tail %b chnl %0d",
                           r, i, got_flit[base+i], got_tail[base+i], got_chnl[base+i], ef[i], et[i], ec[i]);
               end
            end
         end
         vectors++;
         if (got_flit.size() - base !== ef.size() || drops - dbase !== edrops ||
             fifo_count !== 4'd0 || sw_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rand%0d_end: got transfers %0d drops %0d count %0d req %b, required %0d, %0d, 0, 0",
                     r, got_flit.size() - base, drops - dbase, fifo_count, sw_req, ef.size(), edrops);
         end
      end
   endtask

   task automatic test_pktlen1();
      int n = 0;
      p1_sw_gnt = 1'b1;
      send_flit1(8'hF0);
      send_flit1(8'h8A);
      while (p1_got_flit.size() < 2 && n < 100) begin tick(); n++; end
      repeat (4) tick();
      vectors++;
      if (p1_got_flit.size() !== 2) begin
         miscompares++;
         $display("FAIL pkt1_count: got %0d transfers, required 2", p1_got_flit.size());
      end else begin
         vectors++;
         if (p1_got_flit[0] !== 8'hF0 || p1_got_tail[0] !== 1'b1 || p1_got_chnl[0] !== 3'd7) begin
            miscompares++;
            $display("FAIL pkt1_first: got flit %h tail %b chnl %0d, required F0 1 7",
                     p1_got_flit[0], p1_got_tail[0], p1_got_chnl[0]);
         end
         vectors++;
         if (p1_got_flit[1] !== 8'h8A || p1_got_tail[1] !== 1'b1 || p1_got_chnl[1] !== 3'd0) begin
            miscompares++;
            $display("FAIL pkt1_second: got flit %h tail %b chnl %0d, required 8A 1 0",
                     p1_got_flit[1], p1_got_tail[1], p1_got_chnl[1]);
         end
      end
      vectors++;
      if (p1_sw_req !== 1'b0 || p1_fifo_count !== 4'd0 || p1_sw_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL pkt1_idle: got req %b count %0d valid %b, required 0 0 0",
                  p1_sw_req, p1_fifo_count, p1_sw_valid);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_orphan();
      test_pause();
      test_reset_mid();
      test_random(8);
      test_pktlen1();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
